// File: rtl/gcd_stein.sv
// gcd_stein: iterative binary (Stein) GCD, one reduction step per clock.
// A load captures the operands; zero operands bypass straight to DONE.
// The result is held in DONE until the next accepted load or reset.
module gcd_stein #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             done,
    output logic             busy,
    output logic             zero
);

    // k counts shared factors of two; it never exceeds WIDTH-1 for nonzero operands
    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [KW-1:0]    k;

    logic accept;
    logic opnd_zero;
    logic both_zero;

    // A load only counts outside CALC; a load during CALC is dropped entirely
    assign accept    = load && (state != CALC);
    assign opnd_zero = (a == '0) || (b == '0);
    assign both_zero = (a == '0) && (b == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode: zero operands skip CALC, equal residues finish CALC
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (load) state_next = opnd_zero ? DONE : CALC;
            end
            CALC: begin
                if (ra == rb) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs: capture on accept, one Stein step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            k    <= '0;
            y    <= '0;
            done <= 1'b0;
            busy <= 1'b0;
            zero <= 1'b0;
        end else if (accept) begin
            ra   <= a;
            rb   <= b;
            k    <= '0;
            done <= opnd_zero;
            busy <= !opnd_zero;
            zero <= both_zero;
            // with one operand zero the GCD is the other one; a|b covers both cases
            if (opnd_zero) y <= a | b;
        end else if (state == CALC) begin
            if (ra == rb) begin
                // restore the common power of two; cannot overflow WIDTH
                y    <= ra << k;
                done <= 1'b1;
                busy <= 1'b0;
            end else if (!ra[0] && !rb[0]) begin
                ra <= ra >> 1;
                rb <= rb >> 1;
                k  <= k + 1'b1;
            end else if (!ra[0]) begin
                ra <= ra >> 1;
            end else if (!rb[0]) begin
                rb <= rb >> 1;
            end else if (ra > rb) begin
                // both odd here, so the difference is even and halving is exact
                ra <= (ra - rb) >> 1;
            end else begin
                rb <= (rb - ra) >> 1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: scoreboard bench for gcd_stein.
// The driver pushes the reference GCD for every accepted load; a monitor
// pops and compares whenever done is seen. Latency counts the load edge as
// edge 1, so a==b finishes on edge 2 and a zero bypass on edge 1.
module tb_gcd_stein;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [7:0]  a, b, y;
    logic        done, busy, zero;

    logic        load16;
    logic [15:0] a16, b16, y16;
    logic        done16, busy16, zero16;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] y;
        logic       z;
        int         lcyc;
        int         lat;    // exact edge count expected, or -1 for the upper bound only
    } exp_t;

    exp_t sb[$];

    gcd_stein #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .load(load), .a(a), .b(b),
        .y(y), .done(done), .busy(busy), .zero(zero)
    );

    gcd_stein #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .load(load16), .a(a16), .b(b16),
        .y(y16), .done(done16), .busy(busy16), .zero(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Euclid by remainder: a different algorithm from the one under test
    function automatic int gcd_ref(input int x, input int yv);
        int t;
        while (yv != 0) begin
            t  = x % yv;
            x  = yv;
            yv = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done seen while an entry is pending retires that entry
    always @(negedge clk) begin
        if (rst_n && done && sb.size() > 0) begin
            exp_t e;
            int   lat;
            e   = sb.pop_front();
            lat = cyc - e.lcyc + 1;
            check("sb_y", y, e.y);
            check("sb_zero", zero, e.z);
            if (e.lat >= 0) check("sb_lat_exact", lat, e.lat);
            else            check("sb_lat_bound", (lat >= 2 && lat <= 17) ? 1 : 0, 1);
        end
    end

    // Issue one load, push the expectation, then wait for the monitor to retire it.
    // glitch_at >= 0 drives an extra load (a=7,b=3) on that negedge of the wait.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input int glitch_at,
                          output int bcnt);
        exp_t e;
        @(negedge clk);
        load = 1'b1; a = ta; b = tb_;
        @(posedge clk);
        #1;
        e.y    = 8'(gcd_ref(int'(ta), int'(tb_)));
        e.z    = (ta == 0) && (tb_ == 0);
        e.lcyc = cyc;
        e.lat  = (ta == 0 || tb_ == 0) ? 1 : ((ta == tb_) ? 2 : -1);
        sb.push_back(e);
        load = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        bcnt = 0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (i == glitch_at) begin
                load = 1'b1; a = 8'd7; b = 8'd3;
            end else begin
                load = 1'b0;
            end
            #1;
        end
        load = 1'b0;
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL timeout: done not seen for a=%0d b=%0d", ta, tb_);
            sb.delete();
        end
    endtask

    initial begin
        int bc;
        logic [7:0] ra_, rb_;
        rst_n = 1'b0; load = 1'b0; a = '0; b = '0;
        load16 = 1'b0; a16 = '0; b16 = '0;
        #1;
        check("rst_y", y, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_zero", zero, 0);
        check("rst_y16", y16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 50,20: five busy cycles, result 10, then held
        run_op(8'd50, 8'd20, -1, bc);
        check("busy_cycles_50_20", bc, 5);
        repeat (3) @(negedge clk);
        check("hold_y", y, 10);
        check("hold_done", done, 1);
        check("hold_busy", busy, 0);

        // zero bypass cases: busy must never rise
        run_op(8'd0, 8'd36, -1, bc);
        check("bypass_busy", bc, 0);
        run_op(8'd0, 8'd0, -1, bc);
        check("bypass00_busy", bc, 0);
        run_op(8'd36, 8'd0, -1, bc);

        // load during CALC (second CALC cycle) is ignored; result stays 6
        run_op(8'd48, 8'd18, 1, bc);
        repeat (2) @(negedge clk);
        check("ignored_load_y", y, 6);

        // reset mid-CALC aborts without done
        @(negedge clk);
        load = 1'b1; a = 8'd200; b = 8'd150;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("midcalc_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_y", y, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd200, 8'd150, -1, bc);

        // 16-bit instance: equal operands finish on edge 2, then 48,18
        @(negedge clk);
        load16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge clk);
        load16 = 1'b0;
        check("w16_edge1_done", done16, 0);
        check("w16_edge1_busy", busy16, 1);
        @(negedge clk);
        check("w16_edge2_done", done16, 1);
        check("w16_eq_y", y16, 65535);
        load16 = 1'b1; a16 = 16'd48; b16 = 16'd18;
        @(negedge clk);
        load16 = 1'b0;
        check("w16_reload_clears_done", done16, 0);
        for (int i = 0; i < 40 && !done16; i++) @(negedge clk);
        check("w16_done", done16, 1);
        check("w16_y", y16, 6);

        // randomised pairs, with some equal and zero operands mixed in
        for (int n = 0; n < 60; n++) begin
            ra_ = 8'($urandom);
            rb_ = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb_ = ra_;
                1: ra_ = 8'd0;
                2: ra_ = ra_ << $urandom_range(0, 4);
                default: ;
            endcase
            run_op(ra_, rb_, -1, bc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/gcd_stein.md
GCD_STEIN -- requirements
Module: gcd_stein

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; legal values are WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: load  input  1  start request; sampled on the rising edge.
REQ-005 Port: a  input  WIDTH  operand A, unsigned; sampled only on an accepted load.
REQ-006 Port: b  input  WIDTH  operand B, unsigned; sampled only on an accepted load.
REQ-007 Port: y  output  WIDTH  GCD(a,b) result; valid while done=1.
REQ-008 Port: done  output  1  result valid; held high until the next accepted load or reset.
REQ-009 Port: busy  output  1  high while in CALC.
REQ-010 Port: zero  output  1  high with done when both operands were 0.

Function
REQ-011 The block SHALL implement an FSM with three states: IDLE, CALC and DONE.
REQ-012 load SHALL be accepted in IDLE or DONE; load in CALC SHALL be ignored with no effect on state.
REQ-013 On an accepted load, internal registers SHALL capture ra=a, rb=b and k=0, and done SHALL clear.
- Counter width: k SHALL be ceil(log2(WIDTH+1)) bits.
REQ-014 Zero bypass: on an accepted load with a==0 or b==0, the FSM SHALL go directly to DONE.
- y = a|b.
- zero = (a==0 && b==0).
- done=1 after that same edge.
REQ-015 Otherwise, an accepted load SHALL move the FSM to CALC with busy=1.
REQ-016 CALC SHALL perform exactly one step per cycle, taking the first matching rule in priority order:
- (1) ra==rb: y = ra<<k, go to DONE.
- (2) ra and rb both even: ra>>=1, rb>>=1, k+=1.
- (3) ra even: ra>>=1.
- (4) rb even: rb>>=1.
- (5) ra>rb: ra = (ra-rb)>>1.
- (6) otherwise: rb = (rb-ra)>>1.
REQ-017 Arithmetic SHALL be unsigned and WIDTH bits wide; subtraction in rules 5 and 6 never underflows, and ra<<k never exceeds the smaller original operand.
REQ-018 Latency: for nonzero operands, done SHALL assert no later than 2*WIDTH+1 clock edges after the load edge; for a==b it SHALL assert exactly 2 edges after the load edge.
REQ-019 In DONE, y, done and zero SHALL hold stable until an accepted load; busy=0.
REQ-020 A load accepted in DONE SHALL clear done and zero on that edge and start a new operation per REQ-013 to REQ-016.
REQ-021 Operand inputs a and b SHALL be ignored outside accepted loads; changes during CALC SHALL NOT affect the result.
REQ-022 There SHALL be no combinational path from inputs to outputs; all outputs are registered.

Reset
REQ-023 On rst_n=0, at any time and in any state, the block SHALL go immediately to IDLE.
- Outputs: y=0, done=0, busy=0, zero=0.
- Internal registers: ra=0, rb=0, k=0.
REQ-024 Assertion of rst_n=0 during CALC SHALL abort the operation without asserting done.
REQ-025 After rst_n deasserts, the first rising edge with load=1 SHALL be accepted.

Verification
REQ-026 WIDTH=8, a=50, b=20, load for one cycle -> busy for 5 cycles, then y=10, done=1, zero=0, held until the next load.
REQ-027 WIDTH=8, a=0, b=36 -> y=36, done=1 after the load edge, busy never high; repeat with a=0, b=0 -> y=0, zero=1.
REQ-028 WIDTH=16, a=65535, b=65535 -> y=65535, done=1 two edges after load; then a=48, b=18 -> y=6.
REQ-029 WIDTH=8, a=48, b=18 loaded; at CALC cycle 2 drive load=1 with a=7, b=3 -> second load ignored, final y=6.
REQ-030 WIDTH=8, a=200, b=150 loaded; rst_n=0 mid-CALC -> y=0, done=0, busy=0 immediately; a reload after reset gives y=50.
REQ-031 Randomised WIDTH=8 operand pairs versus a reference model -> y matches, and done arrives within 17 edges of the load edge every time.
